// File: rtl/clock_period_meter.sv
// clock_period_meter: measures period and high time of a slow external square
// wave in clk_in cycles and hands each result out over a valid/ready pair.
//
// state   | meaning
// IDLE    | disabled, counters held at 0
// ARM     | waiting for the first rise to start a measurement
// MEASURE | counting between rises, publishing on every rise
`timescale 1ns/1ps
module clock_period_meter #(
  parameter int unsigned CNT_W   = 31,
  parameter int unsigned TIMEOUT = 500000000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             timeout,
  output logic             overrun
);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             hist_q, hist_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             overrun_q, overrun_d;
  logic             rise;
  logic             publish;
  logic             tmo_hit;
  logic             accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Two-flop synchronizer plus history flop for rise detection.
  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    rise    = sync2_q & ~hist_q;
  end

  // Next state and counter updates; en low overrides everything.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    publish = 1'b0;
    tmo_hit = 1'b0;
    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = ARM;
        end
        ARM: begin
          hcnt_d = '0;
          if (rise) begin
            state_d = MEASURE;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end else if (cnt_q >= TMO) begin
            tmo_hit = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        MEASURE: begin
          // A rise on the timeout cycle still counts as a valid edge.
          if (rise) begin
            publish = 1'b1;
            cnt_d   = CNT_ONE;
            hcnt_d  = CNT_ONE;
          end else if (cnt_q >= TMO) begin
            tmo_hit = 1'b1;
            state_d = ARM;
            cnt_d   = '0;
            hcnt_d  = '0;
          end else begin
            cnt_d = sat_inc(cnt_q);
            if (sync2_q) hcnt_d = sat_inc(hcnt_q);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hcnt_d  = '0;
        end
      endcase
    end
  end

  // Result register, handshake and sticky status.
  always_comb begin
    accept    = valid_q & result_ready;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = valid_q;
    timeout_d = timeout_q;
    overrun_d = overrun_q;
    if (accept) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
    if (tmo_hit) timeout_d = 1'b1;
    if (publish) begin
      timeout_d = 1'b0;
      if (valid_q && !result_ready) begin
        overrun_d = 1'b1;
      end else begin
        period_d = cnt_q;
        high_d   = hcnt_q;
        valid_d  = 1'b1;
      end
    end
  end

  // All state flops, cleared asynchronously.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      hist_q    <= hist_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      overrun_q <= overrun_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign result_valid = valid_q;
  assign timeout      = timeout_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Bench for clock_period_meter: table-driven steady waves, hand-written corner
// sequences, and a randomized phase checked against a timeline reference model.
`timescale 1ns/1ps
module tb_clock_period_meter;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 1000;

  logic             clk_in = 1'b0;
  logic             rst_n  = 1'b0;
  logic             en     = 1'b0;
  logic             sig_in = 1'b0;
  logic             result_ready = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             result_valid;
  logic             timeout;
  logic             overrun;

  int checks   = 0;
  int failures = 0;

  clock_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .en          (en),
    .sig_in      (sig_in),
    .period      (period),
    .high_time   (high_time),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .timeout     (timeout),
    .overrun     (overrun)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Reference model: tracks the edge index where the current count started
  // and derives period as elapsed edges. The input path is modelled as a
  // history of sampled sig_in values; a rise is seen two edges after sampling.
  logic [CNT_W-1:0] m_period = '0, m_high = '0;
  bit     m_valid = 0, m_timeout = 0, m_over = 0;
  bit     h1 = 0, h2 = 0, h3 = 0;
  bit     active = 0, have_ref = 0;
  longint edge_no = 0, origin = 0, elapsed = 0, p_val = 0;
  int     highs = 0;

  always @(posedge clk_in or negedge rst_n) begin
    bit rise_ev, pub;
    if (!rst_n) begin
      m_period = '0; m_high = '0; m_valid = 0; m_timeout = 0; m_over = 0;
      h1 = 0; h2 = 0; h3 = 0; active = 0; have_ref = 0; highs = 0;
    end else begin
      edge_no++;
      rise_ev = h2 && !h3;
      pub = 0;
      if (!active) begin
        if (en) begin active = 1; have_ref = 0; origin = edge_no + 1; highs = 0; end
      end else if (!en) begin
        active = 0;
      end else begin
        elapsed = edge_no - origin;
        if (rise_ev) begin
          if (have_ref) begin pub = 1; p_val = elapsed; end
          have_ref = 1; origin = edge_no;
        end else if (elapsed >= TIMEOUT) begin
          m_timeout = 1; have_ref = 0; origin = edge_no + 1; highs = 0;
        end else if (have_ref && h2) begin
          highs++;
        end
      end
      if (m_valid && result_ready) begin m_valid = 0; m_over = 0; end
      if (pub) begin
        m_timeout = 0;
        if (m_valid) m_over = 1;
        else begin m_period = CNT_W'(p_val); m_high = CNT_W'(highs); m_valid = 1; end
      end
      if (rise_ev && active && en) highs = 1;
      h3 = h2; h2 = h1; h1 = sig_in;
    end
  end

  bit mchk_on = 0;
  always @(negedge clk_in) begin
    if (mchk_on) begin
      chk("model_period", period, m_period);
      chk("model_high_time", high_time, m_high);
      chk("model_valid", result_valid, m_valid);
      chk("model_timeout", timeout, m_timeout);
      chk("model_overrun", overrun, m_over);
    end
  end

  // Publish monitor for phases where result_ready is held high.
  int pub_cnt = 0;
  logic [CNT_W-1:0] last_p = '0, last_h = '0;
  always @(negedge clk_in) begin
    if (rst_n && result_valid) begin
      pub_cnt++;
      last_p = period;
      last_h = high_time;
    end
  end

  typedef struct {
    int high;
    int low;
    int rises;
    int exp_period;
    int exp_high;
  } vec_t;
  vec_t tbl[6];

  task automatic restart(input logic rdy);
    en = 1'b0; sig_in = 1'b0; result_ready = rdy;
    cycles(3);
    pub_cnt = 0;
    en = 1'b1;
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      sig_in = 1'b1; cycles(h);
      sig_in = 1'b0; cycles(l);
    end
  endtask

  // n rises; the last one is followed only by its high phase and a short tail.
  task automatic pulses(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      sig_in = 1'b1; cycles(h);
      sig_in = 1'b0;
      if (k < n - 1) cycles(l);
    end
    cycles(4);
  endtask

  initial begin
    #1_500_000;
    checks++; failures++;
    $display("FAIL watchdog: actual=expired required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    tbl[0] = '{high: 40, low: 60,  rises: 4, exp_period: 100,  exp_high: 40};
    tbl[1] = '{high: 1,  low: 9,   rises: 4, exp_period: 10,   exp_high: 1};
    tbl[2] = '{high: 5,  low: 5,   rises: 4, exp_period: 10,   exp_high: 5};
    tbl[3] = '{high: 99, low: 1,   rises: 4, exp_period: 100,  exp_high: 99};
    tbl[4] = '{high: 3,  low: 997, rises: 3, exp_period: 1000, exp_high: 3};
    tbl[5] = '{high: 1,  low: 1,   rises: 5, exp_period: 2,    exp_high: 1};

    // Reset state
    cycles(3);
    #2 rst_n = 1'b1;
    cycles(1);
    mchk_on = 1;
    chk("reset_period", period, 0);
    chk("reset_high_time", high_time, 0);
    chk("reset_valid", result_valid, 0);
    chk("reset_timeout", timeout, 0);
    chk("reset_overrun", overrun, 0);

    // Steady waves from the table, ready held high
    for (int i = 0; i < 6; i++) begin
      restart(1'b1);
      pulses(tbl[i].high, tbl[i].low, tbl[i].rises);
      chk($sformatf("tbl%0d_period", i), last_p, tbl[i].exp_period);
      chk($sformatf("tbl%0d_high", i), last_h, tbl[i].exp_high);
      chk($sformatf("tbl%0d_pubs", i), pub_cnt, tbl[i].rises - 1);
      chk($sformatf("tbl%0d_timeout", i), timeout, 0);
    end

    // Backpressure: first result held, second dropped with overrun
    restart(1'b0);
    wave(40, 60, 1);
    wave(30, 90, 1);
    chk("bp_valid", result_valid, 1);
    chk("bp_period", period, 100);
    chk("bp_high", high_time, 40);
    chk("bp_overrun_clear", overrun, 0);
    wave(40, 60, 1);
    chk("bp_hold_valid", result_valid, 1);
    chk("bp_hold_period", period, 100);
    chk("bp_hold_high", high_time, 40);
    chk("bp_overrun_set", overrun, 1);
    result_ready = 1'b1; cycles(1); result_ready = 1'b0;
    chk("bp_accept_valid", result_valid, 0);
    chk("bp_accept_overrun", overrun, 0);

    // Timeout exactly 1000 cycles after the last rise
    restart(1'b0);
    wave(40, 60, 1);
    sig_in = 1'b1; cycles(40);
    sig_in = 1'b0; cycles(962);
    chk("to_before", timeout, 0);
    cycles(1);
    chk("to_at_1000", timeout, 1);
    chk("to_valid_kept", result_valid, 1);
    chk("to_period_kept", period, 100);
    result_ready = 1'b1; cycles(2);
    chk("to_handshake_valid", result_valid, 0);
    chk("to_sticky_after_handshake", timeout, 1);
    pub_cnt = 0;
    wave(40, 60, 1);
    chk("to_after_arm_rise", timeout, 1);
    wave(40, 60, 1);
    chk("to_cleared_by_publish", timeout, 0);
    chk("to_resume_pubs", pub_cnt, 1);
    chk("to_resume_period", last_p, 100);

    // Enable drop mid-period
    restart(1'b1);
    wave(40, 60, 2);
    sig_in = 1'b1; cycles(40);
    sig_in = 1'b0; cycles(20);
    en = 1'b0; cycles(10);
    en = 1'b1; cycles(30);
    pub_cnt = 0;
    wave(40, 60, 2);
    cycles(4);
    chk("en_drop_pubs", pub_cnt, 1);
    chk("en_drop_period", last_p, 100);
    chk("en_drop_high", last_h, 40);

    // Reset in the middle of a measurement
    restart(1'b0);
    wave(40, 60, 2);
    chk("rm_pre_valid", result_valid, 1);
    sig_in = 1'b1; cycles(20);
    #2 rst_n = 1'b0;
    #1;
    chk("rm_period", period, 0);
    chk("rm_high_time", high_time, 0);
    chk("rm_valid", result_valid, 0);
    chk("rm_timeout", timeout, 0);
    chk("rm_overrun", overrun, 0);
    sig_in = 1'b0;
    cycles(2);
    #2 rst_n = 1'b1;
    cycles(1);
    chk("rm_release_valid", result_valid, 0);
    wave(40, 60, 1);
    cycles(5);
    chk("rm_first_rise_nopub", result_valid, 0);

    // Publish colliding with a handshake
    restart(1'b0);
    wave(40, 60, 1);
    wave(25, 95, 1);
    chk("col_pre_period", period, 100);
    sig_in = 1'b1; cycles(2);
    result_ready = 1'b1; cycles(1);
    result_ready = 1'b0;
    chk("col_valid", result_valid, 1);
    chk("col_period", period, 120);
    chk("col_high", high_time, 25);
    chk("col_overrun", overrun, 0);
    cycles(37);
    sig_in = 1'b0; cycles(60);

    // Randomized phase against the reference model
    for (int seg = 0; seg < 70; seg++) begin
      int h;
      int l;
      h = $urandom_range(1, 80);
      l = ($urandom_range(0, 9) == 0) ? $urandom_range(900, 1100) : $urandom_range(1, 150);
      if ($urandom_range(0, 11) == 0) begin
        en = 1'b0;
        cycles($urandom_range(1, 5));
        en = 1'b1;
      end
      sig_in = 1'b1;
      for (int c = 0; c < h; c++) begin
        result_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk_in);
      end
      sig_in = 1'b0;
      for (int c = 0; c < l; c++) begin
        result_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk_in);
      end
    end

    mchk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
